// File: rtl/song_pkg.sv
// Shared definitions for the song reader: default field widths, ROM entry
// layout and the sequencer state enumeration.
package song_pkg;

  localparam int NOTE_W_DEF  = 6;
  localparam int DUR_W_DEF   = 6;
  localparam int PARAM_W_DEF = 3;

  // Entry layout, LSB first: parameters, duration, note, voice, chord (MSB).
  localparam int PARAM_LSB = 0;
  localparam int DUR_LSB   = PARAM_LSB + PARAM_W_DEF;
  localparam int NOTE_LSB  = DUR_LSB + DUR_W_DEF;
  localparam int VOICE_LSB = NOTE_LSB + NOTE_W_DEF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

endpackage

// File: rtl/song_rom.sv
// Song ROM with one cycle of synchronous read latency; address = {song, position}.
module song_rom
  import song_pkg::*;
#(
  parameter int NUM_SONGS      = 4,
  parameter int NOTES_PER_SONG = 32,
  parameter int NUM_VOICES     = 3,
  parameter int ENTRY_W        = 18
) (
  input  logic                                                 clk,
  input  logic [$clog2(NUM_SONGS)+$clog2(NOTES_PER_SONG)-1:0] addr,
  output logic [ENTRY_W-1:0]                                   data
);

  localparam int POS_W   = $clog2(NOTES_PER_SONG);
  localparam int VOICE_W = $clog2(NUM_VOICES);
  localparam int AW      = $clog2(NUM_SONGS) + POS_W;

  // Song 1 opens with a three-note chord and ends at entry 5; song 3 mixes
  // chords and ends at entry 20; songs 0 and 2 run the full length.
  function automatic logic [ENTRY_W-1:0] entry_at(input int s, input int i);
    logic [ENTRY_W-1:0] e;
    logic               term;
    logic               chord;
    int                 v;
    term  = (s == 1 && i == 5) || (s == 3 && i == 20);
    chord = (s == 1) ? (i < 3) : ((s == 3) ? (i % 3 == 0) : 1'b0);
    v     = (s == 1 && i < 4) ? (i % NUM_VOICES) : ((i + s) % NUM_VOICES);
    e     = '0;
    e[PARAM_LSB +: PARAM_W_DEF] = PARAM_W_DEF'((i ^ s) & 7);
    e[DUR_LSB +: DUR_W_DEF]     = term ? '0 : DUR_W_DEF'(((i + s) & 7) + 1);
    e[NOTE_LSB +: NOTE_W_DEF]   = NOTE_W_DEF'(s * 13 + i * 7 + 1);
    e[VOICE_LSB +: VOICE_W]     = VOICE_W'(v);
    e[ENTRY_W-1]                = chord;
    return e;
  endfunction

  always_ff @(posedge clk) begin
    data <= entry_at(int'(addr[AW-1:POS_W]), int'(addr[POS_W-1:0]));
  end

endmodule

// File: rtl/poly_song_reader.sv
// Song sequencer: walks a song ROM entry by entry, issuing notes to voices,
// chaining chord entries within one time step and waiting on note_done otherwise.
module poly_song_reader
  import song_pkg::*;
#(
  parameter int NUM_SONGS      = 4,
  parameter int NOTES_PER_SONG = 32,
  parameter int NUM_VOICES     = 3,
  parameter int NOTE_W         = NOTE_W_DEF,
  parameter int DUR_W          = DUR_W_DEF,
  parameter int PARAM_W        = PARAM_W_DEF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              play,
  input  logic                              loop,
  input  logic [$clog2(NUM_SONGS)-1:0]      song,
  input  logic                              note_done,
  output logic [NOTE_W-1:0]                 note,
  output logic [DUR_W-1:0]                  duration,
  output logic [PARAM_W-1:0]                parameters,
  output logic [$clog2(NUM_VOICES)-1:0]     voice,
  output logic                              new_note,
  output logic                              song_done,
  output logic                              activate,
  output logic [$clog2(NOTES_PER_SONG)-1:0] position
);

  localparam int SONG_W    = $clog2(NUM_SONGS);
  localparam int POS_W     = $clog2(NOTES_PER_SONG);
  localparam int VOICE_W   = $clog2(NUM_VOICES);
  localparam int CHORD_BIT = VOICE_LSB + VOICE_W;
  localparam int ENTRY_W   = CHORD_BIT + 1;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NOTES_PER_SONG - 1);

  state_t               state, state_nx;
  logic [POS_W-1:0]     position_nx;
  logic                 wrapped, wrapped_nx;
  logic [SONG_W-1:0]    song_q;
  logic [ENTRY_W-1:0]   entry_p1;
  logic [NOTE_W-1:0]    note_nx;
  logic [DUR_W-1:0]     duration_nx;
  logic [PARAM_W-1:0]   parameters_nx;
  logic [VOICE_W-1:0]   voice_nx;
  logic                 new_note_nx, song_done_nx;
  logic                 running, restart, finish;

  song_rom #(
    .NUM_SONGS      (NUM_SONGS),
    .NOTES_PER_SONG (NOTES_PER_SONG),
    .NUM_VOICES     (NUM_VOICES),
    .ENTRY_W        (ENTRY_W)
  ) u_rom (
    .clk  (clk),
    .addr ({song, position}),
    .data (entry_p1)
  );

  assign running  = (state == S_FETCH) || (state == S_ISSUE) || (state == S_WAIT);
  assign restart  = running && (song != song_q);
  assign activate = play && running;

  always_comb begin
    state_nx      = state;
    position_nx   = position;
    wrapped_nx    = wrapped;
    note_nx       = note;
    duration_nx   = duration;
    parameters_nx = parameters;
    voice_nx      = voice;
    new_note_nx   = 1'b0;
    song_done_nx  = 1'b0;
    finish        = 1'b0;
    // A song change overrides everything else, including a pending note_done.
    if (restart) begin
      state_nx    = S_FETCH;
      position_nx = '0;
      wrapped_nx  = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          position_nx = '0;
          wrapped_nx  = 1'b0;
          if (play) state_nx = S_FETCH;
        end
        S_FETCH: if (play) state_nx = S_ISSUE;
        S_ISSUE: if (play) begin
          if (entry_p1[DUR_LSB +: DUR_W] == '0) begin
            finish = 1'b1;
          end else begin
            new_note_nx   = 1'b1;
            note_nx       = entry_p1[NOTE_LSB +: NOTE_W];
            duration_nx   = entry_p1[DUR_LSB +: DUR_W];
            parameters_nx = entry_p1[PARAM_LSB +: PARAM_W];
            voice_nx      = entry_p1[VOICE_LSB +: VOICE_W];
            position_nx   = position + 1'b1;
            // Remember the wrap so the end of song is signalled on the next advance.
            wrapped_nx    = (position == POS_LAST);
            if (!entry_p1[CHORD_BIT])      state_nx = S_WAIT;
            else if (position == POS_LAST) finish   = 1'b1;
            else                           state_nx = S_FETCH;
          end
        end
        S_WAIT: if (play && note_done) begin
          if (wrapped) finish   = 1'b1;
          else         state_nx = S_FETCH;
        end
        S_DONE: if (!play || (song != song_q)) state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
      if (finish) begin
        song_done_nx = 1'b1;
        position_nx  = '0;
        wrapped_nx   = 1'b0;
        state_nx     = loop ? S_FETCH : S_DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      position   <= '0;
      wrapped    <= 1'b0;
      note       <= '0;
      duration   <= '0;
      parameters <= '0;
      voice      <= '0;
      new_note   <= 1'b0;
      song_done  <= 1'b0;
    end else begin
      state      <= state_nx;
      position   <= position_nx;
      wrapped    <= wrapped_nx;
      note       <= note_nx;
      duration   <= duration_nx;
      parameters <= parameters_nx;
      voice      <= voice_nx;
      new_note   <= new_note_nx;
      song_done  <= song_done_nx;
    end
  end

  always_ff @(posedge clk) begin
    song_q <= song;
  end

endmodule

// File: doc/poly_song_reader.md
POLY_SONG_READER -- requirements
Module: poly_song_reader

Interface
REQ-001 Parameter NUM_SONGS, default 4, number of songs stored in ROM.
REQ-002 Parameter NOTES_PER_SONG, default 32, maximum entries per song (power of 2).
REQ-003 Parameter NUM_VOICES, default 3, number of voice channels addressable by an entry.
REQ-004 Parameters NOTE_W=6, DUR_W=6, PARAM_W=3; field widths of note, duration and parameters.
REQ-005 clk  input  1  single system clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 play  input  1  level: 1 = run, 0 = pause.
REQ-008 loop  input  1  level: 1 = restart song at end instead of finishing.
REQ-009 song  input  clog2(NUM_SONGS)  song select.
REQ-010 note_done  input  1  pulse: current time step finished; advance.
REQ-011 note  output  NOTE_W  note of issued entry.
REQ-012 duration  output  DUR_W  duration of issued entry.
REQ-013 parameters  output  PARAM_W  parameters of issued entry.
REQ-014 voice  output  clog2(NUM_VOICES)  target voice of issued entry.
REQ-015 new_note  output  1  one-cycle strobe: note/duration/parameters/voice valid.
REQ-016 song_done  output  1  one-cycle strobe at end of song.
REQ-017 activate  output  1  high while a song is running and play=1.
REQ-018 position  output  clog2(NOTES_PER_SONG)  current entry index within song.

Function
REQ-019 ROM entry = {chord, voice, note, duration, parameters}; ROM address = {song, position}; read latency 1 cycle.
REQ-020 States: IDLE, FETCH, ISSUE, WAIT, DONE.
REQ-021 IDLE: position=0; play=1 -> FETCH.
REQ-022 FETCH: one cycle for ROM read -> ISSUE.
REQ-023 ISSUE: if duration==0 (terminator) treat as end of song; else drive outputs and pulse new_note for exactly one cycle, position increments.
REQ-024 After ISSUE with chord=1 -> FETCH of next entry (same time step, no note_done wait); chord=0 -> WAIT.
REQ-025 WAIT: note_done=1 and play=1 -> FETCH; note_done while play=0 is ignored (not stored).
REQ-026 End of song = terminator or position wrap from NOTES_PER_SONG-1: song_done pulses one cycle; loop=1 -> position=0, FETCH; loop=0 -> DONE.
REQ-027 Last entry at NOTES_PER_SONG-1 issues normally; song_done asserts when the following advance would wrap, in the cycle the WAIT exit occurs.
REQ-028 DONE: holds; play=0 or song change -> IDLE.
REQ-029 play=0 in FETCH/ISSUE/WAIT: state, position, outputs frozen; no new_note; resume continues from the same point.
REQ-030 song changes while not IDLE: next cycle -> position=0, FETCH of new song; pending note_done discarded.
REQ-031 activate = play AND state in {FETCH, ISSUE, WAIT}.
REQ-032 note/duration/parameters/voice hold last issued value between strobes.
REQ-033 Simultaneous note_done and song change: song change wins.

Reset
REQ-034 On reset: state IDLE, position 0, note/duration/parameters/voice 0, new_note/song_done/activate 0.
REQ-035 Reset mid-song aborts without song_done pulse; first FETCH after release starts at entry 0.

Structure
REQ-036 Shared package song_pkg holds NOTE_W, DUR_W, PARAM_W defaults, entry field offsets, and the state enumeration.
REQ-037 ROM is a separate sub-module song_rom (synchronous read, parameterised by NUM_SONGS, NOTES_PER_SONG, entry width).

Verification
REQ-038 Reset, play=1, song=0, note_done pulsed each 10 cycles -> new_note 3 cycles after each pulse, position 0,1,2... in order.
REQ-039 Song with entries 0..2 chord=1, entry 3 chord=0 -> four new_note strobes on consecutive issue slots, voices 0,1,2,0, single WAIT.
REQ-040 Terminator at entry 5, loop=0 -> song_done one cycle, activate falls, no further new_note until play toggles 0->1.
REQ-041 Same song with loop=1 -> song_done one cycle then new_note with entry 0 contents, position=0.
REQ-042 play=0 for 50 cycles with note_done pulses during WAIT -> no strobes, position unchanged; play=1 then note_done -> next entry issued.
REQ-043 song 1->2 mid-WAIT and reset asserted at entry 7 -> entry 0 of song 2 issued; after reset all outputs 0, state IDLE.
